// File: rtl/serial_tx_arbiter.sv
// -----------------------------------------------------------------------------
// serial_tx_arbiter
//   Shares one UART transmit path between a command byte source and a stream
//   of multi-byte data words. Each data word goes out as an atomic frame of
//   WORD_BYTES bytes, MSB first. Commands have priority, but only CMD_BURST
//   command bytes in a row may be sent while a data word is waiting. This
//   keeps the data stream from starving.
//
//   Optional build macro FRAME_SYNC_EN: when defined, every data frame is
//   preceded by SYNC_BYTE. A flush while the marker is on the wire aborts the
//   frame before any data byte is sent.
//
// Ports
//   clk          system clock
//   rst          synchronous active-high reset
//   cmd_req      command byte pending (held until cmd_ack)
//   cmd_byte     command byte, stable while cmd_req is high
//   cmd_ack      1-cycle pulse: cmd_byte captured
//   word_valid   data word available (FIFO not empty)
//   word_in      FIFO head word (first-word-fall-through)
//   word_ready   1-cycle pulse: word captured, pops the FIFO
//   flush        abort the rest of the current frame at the next byte boundary
//   tx_busy      UART busy
//   tx_data      byte to the UART
//   new_tx_data  1-cycle strobe: tx_data valid
//   frame_active high from word capture until the last frame byte finishes
// -----------------------------------------------------------------------------
module serial_tx_arbiter #(
    parameter int WORD_BYTES = 6,
    parameter int CMD_BURST  = 4
`ifdef FRAME_SYNC_EN
    ,
    parameter logic [7:0] SYNC_BYTE = 8'hA5
`endif
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    cmd_req,
    input  logic [7:0]              cmd_byte,
    output logic                    cmd_ack,
    input  logic                    word_valid,
    input  logic [8*WORD_BYTES-1:0] word_in,
    output logic                    word_ready,
    input  logic                    flush,
    input  logic                    tx_busy,
    output logic [7:0]              tx_data,
    output logic                    new_tx_data,
    output logic                    frame_active
);

    localparam int W     = 8 * WORD_BYTES;
    localparam int IDX_W = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;
    localparam int BC_W  = $clog2(CMD_BURST + 1);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(WORD_BYTES - 1);
    localparam logic [BC_W-1:0]  BURST_MAX = BC_W'(CMD_BURST);

`ifdef FRAME_SYNC_EN
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SEND  = 3'd1,
        GUARD = 3'd2,
        DRAIN = 3'd3,
        SYNC  = 3'd4
    } state_t;
    localparam state_t FRAME_START = SYNC;
`else
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SEND  = 2'd1,
        GUARD = 2'd2,
        DRAIN = 2'd3
    } state_t;
    localparam state_t FRAME_START = SEND;
`endif

    state_t           state_q, state_d;
    logic [W-1:0]     shift_q, shift_d;
    logic [IDX_W-1:0] byte_idx_q, byte_idx_d;
    logic [BC_W-1:0]  burst_cnt_q, burst_cnt_d;
    logic             src_data_q, src_data_d;
    logic [7:0]       tx_data_q, tx_data_d;
    logic             new_tx_data_q, new_tx_data_d;
    logic             cmd_ack_q, cmd_ack_d;
    logic             word_ready_q, word_ready_d;
    logic             frame_active_q, frame_active_d;
    logic             after_marker_s;

`ifdef FRAME_SYNC_EN
    logic             marker_q, marker_d;

    // Marker flag: set when the frame marker is strobed, cleared once it drains.
    always_comb begin
        marker_d = marker_q;
        if (state_q == SYNC && !tx_busy) begin
            marker_d = 1'b1;
        end else if (state_q == DRAIN && !tx_busy) begin
            marker_d = 1'b0;
        end else begin
            marker_d = marker_q;
        end
    end

    // Marker flag register.
    always_ff @(posedge clk) begin
        if (rst) begin
            marker_q <= 1'b0;
        end else begin
            marker_q <= marker_d;
        end
    end

    assign after_marker_s = marker_q;
`else
    assign after_marker_s = 1'b0;
`endif

    // Next-state and output decode for the arbitration / byte-serialising FSM.
    always_comb begin
        state_d        = state_q;
        shift_d        = shift_q;
        byte_idx_d     = byte_idx_q;
        burst_cnt_d    = burst_cnt_q;
        src_data_d     = src_data_q;
        tx_data_d      = tx_data_q;
        new_tx_data_d  = 1'b0;
        cmd_ack_d      = 1'b0;
        word_ready_d   = 1'b0;
        frame_active_d = frame_active_q;

        case (state_q)
            IDLE: begin
                if (cmd_req && (!word_valid || (burst_cnt_q < BURST_MAX))) begin
                    // Command goes out through the same top-byte path as data.
                    shift_d    = {cmd_byte, {(W-8){1'b0}}};
                    cmd_ack_d  = 1'b1;
                    src_data_d = 1'b0;
                    // Only commands that overtake a waiting word count toward the burst.
                    if (!word_valid) begin
                        burst_cnt_d = {BC_W{1'b0}};
                    end else if (burst_cnt_q != BURST_MAX) begin
                        burst_cnt_d = burst_cnt_q + BC_W'(1);
                    end else begin
                        burst_cnt_d = burst_cnt_q;
                    end
                    state_d = SEND;
                end else if (word_valid && !flush) begin
                    shift_d        = word_in;
                    word_ready_d   = 1'b1;
                    frame_active_d = 1'b1;
                    byte_idx_d     = {IDX_W{1'b0}};
                    burst_cnt_d    = {BC_W{1'b0}};
                    src_data_d     = 1'b1;
                    state_d        = FRAME_START;
                end else begin
                    if (!word_valid) begin
                        burst_cnt_d = {BC_W{1'b0}};
                    end else begin
                        burst_cnt_d = burst_cnt_q;
                    end
                    state_d = IDLE;
                end
            end
`ifdef FRAME_SYNC_EN
            SYNC: begin
                if (!tx_busy) begin
                    tx_data_d     = SYNC_BYTE;
                    new_tx_data_d = 1'b1;
                    state_d       = GUARD;
                end else begin
                    state_d = state_q;
                end
            end
`endif
            SEND: begin
                if (!tx_busy) begin
                    tx_data_d     = shift_q[W-1 -: 8];
                    new_tx_data_d = 1'b1;
                    state_d       = GUARD;
                end else begin
                    state_d = state_q;
                end
            end
            GUARD: begin
                // The UART raises tx_busy one cycle after the strobe; skip that cycle.
                state_d = DRAIN;
            end
            DRAIN: begin
                if (!tx_busy) begin
                    if (!flush && after_marker_s) begin
                        // Marker done; first data byte is already at the top of the shift reg.
                        state_d = SEND;
                    end else if (!flush && src_data_q && (byte_idx_q < LAST_IDX)) begin
                        shift_d    = {shift_q[W-9:0], 8'h00};
                        byte_idx_d = byte_idx_q + IDX_W'(1);
                        state_d    = SEND;
                    end else begin
                        frame_active_d = 1'b0;
                        state_d        = IDLE;
                    end
                end else begin
                    state_d = state_q;
                end
            end
            default: begin
                frame_active_d = 1'b0;
                state_d        = IDLE;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= IDLE;
            shift_q        <= {W{1'b0}};
            byte_idx_q     <= {IDX_W{1'b0}};
            burst_cnt_q    <= {BC_W{1'b0}};
            src_data_q     <= 1'b0;
            tx_data_q      <= 8'h00;
            new_tx_data_q  <= 1'b0;
            cmd_ack_q      <= 1'b0;
            word_ready_q   <= 1'b0;
            frame_active_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            shift_q        <= shift_d;
            byte_idx_q     <= byte_idx_d;
            burst_cnt_q    <= burst_cnt_d;
            src_data_q     <= src_data_d;
            tx_data_q      <= tx_data_d;
            new_tx_data_q  <= new_tx_data_d;
            cmd_ack_q      <= cmd_ack_d;
            word_ready_q   <= word_ready_d;
            frame_active_q <= frame_active_d;
        end
    end

    assign tx_data      = tx_data_q;
    assign new_tx_data  = new_tx_data_q;
    assign cmd_ack      = cmd_ack_q;
    assign word_ready   = word_ready_q;
    assign frame_active = frame_active_q;

endmodule

// File: tb/tb_serial_tx_arbiter.sv
// -----------------------------------------------------------------------------
// tb_serial_tx_arbiter
//   Directed bench for serial_tx_arbiter. A 10-cycle UART busy model, a
//   command source, and a FWFT word FIFO drive the DUT. A transaction-level
//   model of the arbitration rules checks the handshakes, transmitted bytes,
//   strobe spacing and frame_active on every cycle. Each test also compares
//   its transmitted byte log against a hand-written expected list.
// -----------------------------------------------------------------------------
module tb_serial_tx_arbiter;

    localparam int CMD_BURST = 4;
`ifdef FRAME_SYNC_EN
    localparam int PFX = 1;
`else
    localparam int PFX = 0;
`endif

    logic        clk;
    logic        rst;
    logic        cmd_req;
    logic [7:0]  cmd_byte;
    logic        cmd_ack;
    logic        word_valid;
    logic [47:0] word_in;
    logic        word_ready;
    logic        flush;
    logic        tx_busy;
    logic [7:0]  tx_data;
    logic        new_tx_data;
    logic        frame_active;

    serial_tx_arbiter dut (
        .clk          (clk),
        .rst          (rst),
        .cmd_req      (cmd_req),
        .cmd_byte     (cmd_byte),
        .cmd_ack      (cmd_ack),
        .word_valid   (word_valid),
        .word_in      (word_in),
        .word_ready   (word_ready),
        .flush        (flush),
        .tx_busy      (tx_busy),
        .tx_data      (tx_data),
        .new_tx_data  (new_tx_data),
        .frame_active (frame_active)
    );

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // UART model: busy for 10 cycles starting the cycle after each strobe.
    int busy_cnt = 0;
    always @(posedge clk) begin
        if (new_tx_data) busy_cnt <= 10;
        else if (busy_cnt > 0) busy_cnt <= busy_cnt - 1;
    end
    assign tx_busy = (busy_cnt != 0);

    // Command source and FWFT word FIFO.
    logic [7:0]  cmd_fifo[$];
    logic [47:0] word_fifo[$];

    initial begin
        cmd_req    = 1'b0;
        cmd_byte   = 8'h00;
        word_valid = 1'b0;
        word_in    = 48'h0;
        forever begin
            @(posedge clk);
            #2;
            if (cmd_ack && cmd_fifo.size() > 0) cmd_fifo.delete(0);
            if (word_ready && word_fifo.size() > 0) word_fifo.delete(0);
            cmd_req    = (cmd_fifo.size() > 0);
            cmd_byte   = cmd_req ? cmd_fifo[0] : 8'h00;
            word_valid = (word_fifo.size() > 0);
            word_in    = word_valid ? word_fifo[0] : 48'h0;
        end
    end

    // Inputs as seen by the DUT at each active edge.
    logic        p_rst = 1'b1;
    logic        p_cmd_req = 1'b0;
    logic        p_wv = 1'b0;
    logic        p_flush = 1'b0;
    logic [7:0]  p_cmd = 8'h00;
    logic [47:0] p_word = 48'h0;
    always @(posedge clk) begin
        p_rst     <= rst;
        p_cmd_req <= cmd_req;
        p_wv      <= word_valid;
        p_flush   <= flush;
        p_cmd     <= cmd_byte;
        p_word    <= word_in;
    end

    // Reference model state.
    logic [7:0] exp_q[$];       // bytes of the current transfer still to be sent
    logic [7:0] tx_log[$];      // every byte strobed to the UART
    logic [7:0] exp_log[$];     // per-test hand-written expectation
    bit  data_src  = 1'b0;
    bit  idle_cur  = 1'b1;      // DUT believed idle in the current cycle
    bit  end_next  = 1'b0;      // transfer finished; idle from next cycle
    bit  in_frame  = 1'b0;
    int  mb        = 0;         // model burst count
    int  phase     = 0;         // 0 none, 1 await busy high, 2 await busy low
    int  since     = 100;       // cycles since last strobe
    int  ack_cnt   = 0;
    int  rdy_cnt   = 0;

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        bit was_idle;
        bit e_ack;
        bit e_rdy;
        bit ok;
        if (p_rst) begin
            chk("rst_tx_data", {56'h0, tx_data}, 64'h0);
            chk("rst_new_tx_data", {63'h0, new_tx_data}, 64'h0);
            chk("rst_cmd_ack", {63'h0, cmd_ack}, 64'h0);
            chk("rst_word_ready", {63'h0, word_ready}, 64'h0);
            chk("rst_frame_active", {63'h0, frame_active}, 64'h0);
            exp_q.delete();
            idle_cur = 1'b1;
            end_next = 1'b0;
            in_frame = 1'b0;
            mb       = 0;
            phase    = 0;
            since    = 100;
        end else begin
            was_idle = idle_cur;
            e_ack    = 1'b0;
            e_rdy    = 1'b0;
            if (was_idle) begin
                if (p_cmd_req && (!p_wv || mb < CMD_BURST)) begin
                    e_ack = 1'b1;
                    mb    = p_wv ? ((mb < CMD_BURST) ? mb + 1 : mb) : 0;
                end else if (p_wv && !p_flush) begin
                    e_rdy = 1'b1;
                    mb    = 0;
                end else if (!p_wv) begin
                    mb = 0;
                end
            end
            chk("cmd_ack", {63'h0, cmd_ack}, {63'h0, e_ack});
            chk("word_ready", {63'h0, word_ready}, {63'h0, e_rdy});
            if (cmd_ack) ack_cnt++;
            if (word_ready) rdy_cnt++;
            if (e_ack) begin
                exp_q.delete();
                exp_q.push_back(p_cmd);
                data_src = 1'b0;
            end
            if (e_rdy) begin
                exp_q.delete();
`ifdef FRAME_SYNC_EN
                exp_q.push_back(8'hA5);
`endif
                for (int k = 0; k < 6; k++) exp_q.push_back(p_word[47-8*k -: 8]);
                data_src = 1'b1;
                in_frame = 1'b1;
            end
            if (end_next) begin
                idle_cur = 1'b1;
                in_frame = 1'b0;
                end_next = 1'b0;
            end else if (e_ack || e_rdy) begin
                idle_cur = 1'b0;
            end

            // Byte completion: busy rose after the strobe and has now fallen.
            if (phase == 1 && tx_busy) begin
                phase = 2;
            end else if (phase == 2 && !tx_busy) begin
                phase = 0;
                if (!(data_src && exp_q.size() > 0 && !flush)) begin
                    end_next = 1'b1;
                    exp_q.delete();
                end
            end

            if (new_tx_data) begin
                ok = !idle_cur && exp_q.size() > 0 && phase == 0;
                chk("strobe_legal", {63'h0, ok}, 64'h1);
                if (ok) begin
                    chk("tx_data", {56'h0, tx_data}, {56'h0, exp_q[0]});
                    exp_q.delete(0);
                    phase = 1;
                end
                chk("strobe_gap", {63'h0, (since >= 2)}, 64'h1);
                since = 0;
                tx_log.push_back(tx_data);
            end else begin
                since++;
            end
            chk("frame_active", {63'h0, frame_active}, {63'h0, in_frame});
        end
    end

    task automatic add_frame(input logic [47:0] w, input int n);
`ifdef FRAME_SYNC_EN
        exp_log.push_back(8'hA5);
`endif
        for (int k = 0; k < n; k++) exp_log.push_back(w[47-8*k -: 8]);
    endtask

    task automatic check_log(input string name);
        chk({name, "_len"}, 64'(tx_log.size()), 64'(exp_log.size()));
        for (int k = 0; k < exp_log.size() && k < tx_log.size(); k++)
            chk(name, {56'h0, tx_log[k]}, {56'h0, exp_log[k]});
    endtask

    task automatic wait_log(input int n, input string name);
        int t;
        t = 0;
        while (tx_log.size() < n && t < 2000) begin
            @(posedge clk);
            t++;
        end
        chk({name, "_timeout"}, {63'h0, (tx_log.size() >= n)}, 64'h1);
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic new_test();
        tx_log.delete();
        exp_log.delete();
    endtask

    // Directed test sequence.
    initial begin
        int a0;
        int r0;
        rst   = 1'b1;
        flush = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // 1: a single data word
        new_test();
        r0 = rdy_cnt;
        word_fifo.push_back(48'h0123456789AB);
        add_frame(48'h0123456789AB, 6);
        wait_log(exp_log.size(), "t1");
        idle_cycles(20);
        check_log("t1_bytes");
        chk("t1_pops", 64'(rdy_cnt - r0), 64'd1);
        chk("t1_frame_end", {63'h0, frame_active}, 64'h0);

        // 2: a single command
        new_test();
        a0 = ack_cnt;
        cmd_fifo.push_back(8'h5C);
        exp_log.push_back(8'h5C);
        wait_log(1, "t2");
        idle_cycles(20);
        check_log("t2_bytes");
        chk("t2_acks", 64'(ack_cnt - a0), 64'd1);

        // 3: contention, commands held continuously with a word waiting
        new_test();
        for (int k = 0; k < 8; k++) cmd_fifo.push_back(8'hC0 + 8'(k));
        word_fifo.push_back(48'h111213141516);
        for (int k = 0; k < 4; k++) exp_log.push_back(8'hC0 + 8'(k));
        add_frame(48'h111213141516, 6);
        for (int k = 4; k < 8; k++) exp_log.push_back(8'hC0 + 8'(k));
        wait_log(exp_log.size(), "t3");
        idle_cycles(20);
        check_log("t3_bytes");

        // 4: command raised mid-frame waits for the frame to finish
        new_test();
        word_fifo.push_back(48'hA1A2A3A4A5A6);
        add_frame(48'hA1A2A3A4A5A6, 6);
        exp_log.push_back(8'h77);
        wait_log(2, "t4_mid");
        #1 cmd_fifo.push_back(8'h77);
        wait_log(exp_log.size(), "t4");
        idle_cycles(20);
        check_log("t4_bytes");

        // 5: flush during the second byte, a command served during flush
        new_test();
        word_fifo.push_back(48'hB1B2B3B4B5B6);
        word_fifo.push_back(48'hC1C2C3C4C5C6);
        add_frame(48'hB1B2B3B4B5B6, 2 - PFX);
        exp_log.push_back(8'h3C);
        add_frame(48'hC1C2C3C4C5C6, 6);
        wait_log(2, "t5_mid");
        #1;
        flush = 1'b1;
        cmd_fifo.push_back(8'h3C);
        r0 = rdy_cnt;
        idle_cycles(60);
        chk("t5_no_pop", 64'(rdy_cnt - r0), 64'd0);
        chk("t5_frame_dropped", {63'h0, frame_active}, 64'h0);
        chk("t5_during_flush_len", 64'(tx_log.size()), 64'(3));
        flush = 1'b0;
        wait_log(exp_log.size(), "t5");
        idle_cycles(20);
        check_log("t5_bytes");

        // 6: reset while draining the first byte of a frame
        new_test();
        word_fifo.push_back(48'hD1D2D3D4D5D6);
        add_frame(48'hD1D2D3D4D5D6, 1 - PFX);
        wait_log(1, "t6_mid");
        repeat (4) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        chk("t6_new_tx_data", {63'h0, new_tx_data}, 64'h0);
        chk("t6_frame_active", {63'h0, frame_active}, 64'h0);
        chk("t6_tx_data", {56'h0, tx_data}, 64'h0);
        idle_cycles(60);
        check_log("t6_bytes");
        chk("t6_word_popped", 64'(word_fifo.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Global time limit.
    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
